// File: rtl/pingpong_chunk_buffer.sv
// rtl/pingpong_chunk_buffer.sv - multi-channel ping-pong chunk buffer between capture, processor and playback
module pingpong_chunk_buffer #(
    parameter int SAMPLE_W = 24,
    parameter int NUM_CH   = 2,
    parameter int CH_W     = 1,
    parameter int DEPTH    = 64,
    parameter int PTR_W    = 6,
    parameter int CNT_W    = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    input  logic [NUM_CH*SAMPLE_W-1:0] in_frame,
    output logic                       out_valid,
    output logic [NUM_CH*SAMPLE_W-1:0] out_frame,
    output logic                       chunk_start,
    output logic                       proc_busy,
    input  logic [PTR_W-1:0]           proc_rd_addr,
    input  logic [CH_W-1:0]            proc_rd_ch,
    output logic [SAMPLE_W-1:0]        proc_rd_data,
    input  logic                       proc_wr_en,
    input  logic [PTR_W-1:0]           proc_wr_addr,
    input  logic [CH_W-1:0]            proc_wr_ch,
    input  logic [SAMPLE_W-1:0]        proc_wr_data,
    input  logic                       proc_done,
    output logic                       overrun,
    output logic [CNT_W-1:0]           overrun_cnt,
    input  logic                       overrun_clr
);
    localparam int FRAME_W = NUM_CH * SAMPLE_W;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    // Sample storage; contents are deliberately not reset.
    logic [SAMPLE_W-1:0] inbank  [2][DEPTH][NUM_CH];
    logic [SAMPLE_W-1:0] outbank [2][DEPTH][NUM_CH];

    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic                fill_sel_q, fill_sel_d;
    logic                proc_busy_q, proc_busy_d;
    logic [1:0]          play_ok_q, play_ok_d;
    logic                out_valid_q, out_valid_d;
    logic [FRAME_W-1:0]  out_frame_q, out_frame_d;
    logic                chunk_start_q, chunk_start_d;
    logic [SAMPLE_W-1:0] proc_rd_data_q, proc_rd_data_d;
    logic                overrun_q, overrun_d;
    logic [CNT_W-1:0]    overrun_cnt_q, overrun_cnt_d;

    logic                proc_bank;
    logic                swap;
    logic                done_ok;
    logic                ovr_event;
    logic [FRAME_W-1:0]  play_word;
    logic [SAMPLE_W-1:0] rd_word;

    // The processor always works on the bank capture is not using.
    assign proc_bank = ~fill_sel_q;
    assign swap      = in_valid && (wr_ptr_q == LAST_PTR);
    assign done_ok   = proc_done && proc_busy_q;
    // A coincident proc_done retires the outgoing chunk, so it is not an overrun.
    assign ovr_event = swap && proc_busy_q && !proc_done;

    // Combinational bank reads: playback frame and channel-selected processor sample.
    always_comb begin
        play_word = '0;
        rd_word   = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            play_word[c*SAMPLE_W +: SAMPLE_W] = outbank[fill_sel_q][wr_ptr_q][c];
            if (proc_rd_ch == CH_W'(c)) begin
                rd_word = inbank[proc_bank][proc_rd_addr][c];
            end
        end
    end

    // Next-state: capture pointer, bank swap, processor ownership and overrun tracking.
    always_comb begin
        wr_ptr_d       = wr_ptr_q;
        fill_sel_d     = fill_sel_q;
        proc_busy_d    = proc_busy_q;
        play_ok_d      = play_ok_q;
        out_valid_d    = in_valid;
        out_frame_d    = out_frame_q;
        chunk_start_d  = swap;
        proc_rd_data_d = rd_word;
        overrun_d      = overrun_q;
        overrun_cnt_d  = overrun_cnt_q;

        if (in_valid) begin
            // DEPTH is a power of two, so the pointer wraps on its own.
            wr_ptr_d    = wr_ptr_q + 1'b1;
            out_frame_d = play_ok_q[fill_sel_q] ? play_word : '0;
        end
        // Done is applied before the swap so a coincident pair hands over cleanly.
        if (done_ok) begin
            proc_busy_d          = 1'b0;
            play_ok_d[proc_bank] = 1'b1;
        end
        if (swap) begin
            fill_sel_d            = ~fill_sel_q;
            play_ok_d[fill_sel_q] = 1'b0;
            proc_busy_d           = 1'b1;
        end
        if (overrun_clr) begin
            overrun_d     = 1'b0;
            overrun_cnt_d = '0;
        end else if (ovr_event) begin
            overrun_d = 1'b1;
            if (overrun_cnt_q != '1) begin
                overrun_cnt_d = overrun_cnt_q + 1'b1;
            end
        end
    end

    // Control and output registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q       <= '0;
            fill_sel_q     <= 1'b0;
            proc_busy_q    <= 1'b0;
            play_ok_q      <= '0;
            out_valid_q    <= 1'b0;
            out_frame_q    <= '0;
            chunk_start_q  <= 1'b0;
            proc_rd_data_q <= '0;
            overrun_q      <= 1'b0;
            overrun_cnt_q  <= '0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            fill_sel_q     <= fill_sel_d;
            proc_busy_q    <= proc_busy_d;
            play_ok_q      <= play_ok_d;
            out_valid_q    <= out_valid_d;
            out_frame_q    <= out_frame_d;
            chunk_start_q  <= chunk_start_d;
            proc_rd_data_q <= proc_rd_data_d;
            overrun_q      <= overrun_d;
            overrun_cnt_q  <= overrun_cnt_d;
        end
    end

    // Bank writes: capture into the fill bank, processor into its own output bank.
    always_ff @(posedge clk) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (in_valid) begin
                inbank[fill_sel_q][wr_ptr_q][c] <= in_frame[c*SAMPLE_W +: SAMPLE_W];
            end
            if (proc_wr_en && proc_busy_q && (proc_wr_ch == CH_W'(c))) begin
                outbank[proc_bank][proc_wr_addr][c] <= proc_wr_data;
            end
        end
    end

    assign out_valid    = out_valid_q;
    assign out_frame    = out_frame_q;
    assign chunk_start  = chunk_start_q;
    assign proc_busy    = proc_busy_q;
    assign proc_rd_data = proc_rd_data_q;
    assign overrun      = overrun_q;
    assign overrun_cnt  = overrun_cnt_q;

endmodule
